// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports and the Data_Memory side of data_memory_arbiter.
// slave is the arbiter's view; master is the requesters plus the memory.
interface data_memory_arbiter_if;
    logic        p0_req_valid;
    logic        p0_req_ready;
    logic        p0_req_write;
    logic [31:0] p0_req_addr;
    logic [31:0] p0_req_wdata;
    logic        p0_rsp_valid;
    logic        p0_rsp_ready;
    logic [31:0] p0_rsp_rdata;
    logic        p0_rsp_err;

    logic        p1_req_valid;
    logic        p1_req_ready;
    logic        p1_req_write;
    logic [31:0] p1_req_addr;
    logic [31:0] p1_req_wdata;
    logic        p1_rsp_valid;
    logic        p1_rsp_ready;
    logic [31:0] p1_rsp_rdata;
    logic        p1_rsp_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        busy;

    modport slave (
        input  p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata, p0_rsp_ready,
        input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata, p1_rsp_ready,
        input  mem_read_data,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
        output mem_read, mem_write, mem_address, mem_write_data, busy
    );

    modport master (
        output p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata, p0_rsp_ready,
        output p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata, p1_rsp_ready,
        output mem_read_data,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata, p0_rsp_err,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err,
        input  mem_read, mem_write, mem_address, mem_write_data, busy
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer for Data_Memory: accept, one memory cycle, then hold the response.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_memory_arbiter #(
    parameter int unsigned MEMORY_SIZE = 4096
) (
    input logic                  clk,
    input logic                  reset,
    data_memory_arbiter_if.slave bus
);
    localparam logic [31:0] NumWords = 32'(MEMORY_SIZE / 4);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        port_q;
    logic        in_range_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        p0_rsp_valid_q;
    logic        p1_rsp_valid_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;

    logic        any_req;
    logic        grant;
    logic        winner;
    logic        win_write;
    logic [29:0] win_word;
    logic [31:0] win_index;
    logic [31:0] win_wdata;
    logic        win_in_range;
    logic        rsp_taken;

`ifdef ARB_ROUND_ROBIN_EN
    // prio_q names the port that wins a tie: the one not granted last.
    logic prio_q;

    always_comb begin
        if (bus.p0_req_valid && bus.p1_req_valid) winner = prio_q;
        else                                      winner = bus.p1_req_valid;
    end
`else
    assign winner = !bus.p0_req_valid;
`endif

    assign any_req      = bus.p0_req_valid || bus.p1_req_valid;
    assign grant        = (state_q == StIdle) && any_req && !reset;
    assign win_write    = winner ? bus.p1_req_write : bus.p0_req_write;
    assign win_word     = winner ? bus.p1_req_addr[31:2] : bus.p0_req_addr[31:2];
    assign win_wdata    = winner ? bus.p1_req_wdata : bus.p0_req_wdata;
    assign win_index    = {2'b00, win_word};
    assign win_in_range = win_index < NumWords;
    assign rsp_taken    = port_q ? bus.p1_rsp_ready : bus.p0_rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            port_q           <= 1'b0;
            in_range_q       <= 1'b0;
            err_q            <= 1'b0;
            rdata_q          <= '0;
            p0_rsp_valid_q   <= 1'b0;
            p1_rsp_valid_q   <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_q           <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q          <= StAccess;
                        port_q           <= winner;
                        in_range_q       <= win_in_range;
                        mem_address_q    <= win_index;
                        mem_write_data_q <= win_wdata;
                        // Out-of-range requests never strobe the memory.
                        mem_read_q       <= !win_write && win_in_range;
                        mem_write_q      <= win_write && win_in_range;
`ifdef ARB_ROUND_ROBIN_EN
                        prio_q           <= !winner;
`endif
                    end
                end
                StAccess: begin
                    state_q          <= StResp;
                    rdata_q          <= mem_read_q ? bus.mem_read_data : 32'd0;
                    err_q            <= !in_range_q;
                    p0_rsp_valid_q   <= !port_q;
                    p1_rsp_valid_q   <= port_q;
                    mem_read_q       <= 1'b0;
                    mem_write_q      <= 1'b0;
                    mem_address_q    <= '0;
                    mem_write_data_q <= '0;
                end
                StResp: begin
                    if (rsp_taken) begin
                        state_q        <= StIdle;
                        rdata_q        <= '0;
                        err_q          <= 1'b0;
                        p0_rsp_valid_q <= 1'b0;
                        p1_rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.p0_req_ready   = grant && !winner;
    assign bus.p1_req_ready   = grant && winner;
    assign bus.p0_rsp_valid   = p0_rsp_valid_q;
    assign bus.p1_rsp_valid   = p1_rsp_valid_q;
    assign bus.p0_rsp_rdata   = p0_rsp_valid_q ? rdata_q : 32'd0;
    assign bus.p1_rsp_rdata   = p1_rsp_valid_q ? rdata_q : 32'd0;
    assign bus.p0_rsp_err     = p0_rsp_valid_q && err_q;
    assign bus.p1_rsp_err     = p1_rsp_valid_q && err_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.busy           = (state_q != StIdle);
endmodule
